puf_challenge_sequencer: RTL and testbench

Clocked initiator for one PUF sub-block. It issues a sequence of 8-bit challenges, arms and clears the sub-block for each one, and collects the single-bit race results into an N-bit response word. It sits between the system-side requester and the ring-oscillator sub-block, which is the responder. It also brings the asynchronous `out`/`done` signals into the `clk` domain.

---
 rtl/puf_pkg.sv | 22 ++
 rtl/puf_sync2.sv | 24 ++
 rtl/puf_challenge_sequencer.sv | 178 +++++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF challenge sequencer.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ARM     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } puf_state_e;

  // Feedback taps c[7]^c[5]^c[4]^c[3]: maximal-length, period 255
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int DEF_CLEAR_CYCLES   = 4;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] c);
    return {c[6:0], ^(c & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/puf_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module puf_sync2 (
  input  logic clk,
  input  logic rst_b_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_b_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Issues LFSR challenges to a ring-oscillator PUF, sequences its reset/enable
// handshake and shifts the synchronized race results into a response word.
//
// state   | meaning
// IDLE    | PUF held in reset, waiting for start
// CLEAR   | PUF in reset for CLEAR_CYCLES before the next challenge
// ARM     | PUF enabled, waiting for done_sync or timeout
// CAPTURE | shift result in, advance challenge, PUF back into reset
// DONE    | one-cycle resp_valid pulse
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int N_BITS         = 16,
  parameter int CLEAR_CYCLES   = DEF_CLEAR_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        seed,
  output logic              busy,
  output logic              resp_valid,
  output logic [N_BITS-1:0] response,
  output logic              timeout_err,
  output logic [7:0]        challenge,
  output logic              puf_enable,
  output logic              puf_reset,
  input  logic              puf_out,
  input  logic              puf_done
);

  localparam int BW = $clog2(N_BITS + 1);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  puf_state_e        state_q, state_d;
  logic [7:0]        chal_q, chal_d;
  logic [N_BITS-1:0] resp_q, resp_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic              tmo_err_q, tmo_err_d;
  logic              out_cap_q, out_cap_d;

  logic              out_sync;
  logic              done_sync;

  puf_sync2 u_sync_out (
    .clk     (clk),
    .rst_b_i (reset),
    .d_i     (puf_out),
    .q_o     (out_sync)
  );

  puf_sync2 u_sync_done (
    .clk     (clk),
    .rst_b_i (reset),
    .d_i     (puf_done),
    .q_o     (done_sync)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      chal_q    <= 8'h00;
      resp_q    <= '0;
      bit_cnt_q <= '0;
      clr_cnt_q <= '0;
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
      out_cap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      chal_q    <= chal_d;
      resp_q    <= resp_d;
      bit_cnt_q <= bit_cnt_d;
      clr_cnt_q <= clr_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
      out_cap_q <= out_cap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    chal_d    = chal_q;
    resp_d    = resp_q;
    bit_cnt_d = bit_cnt_q;
    clr_cnt_d = clr_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    tmo_err_d = tmo_err_q;
    out_cap_d = out_cap_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CLEAR;
          chal_d    = (seed == 8'h00) ? 8'h01 : seed;
          resp_d    = '0;
          bit_cnt_d = '0;
          tmo_err_d = 1'b0;
          clr_cnt_d = CW'(CLEAR_CYCLES - 1);
        end
      end

      ST_CLEAR: begin
        if (clr_cnt_q == '0) begin
          state_d   = ST_ARM;
          tmo_cnt_d = TW'(TIMEOUT_CYCLES - 1);
        end else begin
          clr_cnt_d = clr_cnt_q - 1'b1;
        end
      end

      // done has priority over a timeout landing in the same cycle
      ST_ARM: begin
        if (done_sync) begin
          state_d   = ST_CAPTURE;
          out_cap_d = out_sync;
        end else if (tmo_cnt_q == '0) begin
          state_d   = ST_IDLE;
          tmo_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
      end

      ST_CAPTURE: begin
        resp_d    = (resp_q << 1) | N_BITS'(out_cap_q);
        bit_cnt_d = bit_cnt_q + 1'b1;
        chal_d    = lfsr8_next(chal_q);
        if (bit_cnt_q == BW'(N_BITS - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d   = ST_CLEAR;
          clr_cnt_d = CW'(CLEAR_CYCLES - 1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // PUF reset is reasserted in CAPTURE so done has cleared by the next ARM
  always_comb begin
    busy       = 1'b1;
    resp_valid = 1'b0;
    puf_enable = 1'b0;
    puf_reset  = 1'b1;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_ARM: begin
        puf_enable = 1'b1;
        puf_reset  = 1'b0;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign response    = resp_q;
  assign challenge   = chal_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench: expected challenges and responses are queued at start,
// and popped as the DUT raises puf_enable or pulses resp_valid.
module tb_puf_challenge_sequencer;

  localparam int NB = 4;
  localparam int CC = 4;
  localparam int TO = 20;

  logic          clk;
  logic          reset;
  logic          start;
  logic [7:0]    seed;
  logic          busy;
  logic          resp_valid;
  logic [NB-1:0] response;
  logic          timeout_err;
  logic [7:0]    challenge;
  logic          puf_enable;
  logic          puf_reset;
  logic          puf_out;
  logic          puf_done;

  int compared   = 0;
  int mismatched = 0;

  puf_challenge_sequencer #(
    .N_BITS         (NB),
    .CLEAR_CYCLES   (CC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .seed        (seed),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .response    (response),
    .timeout_err (timeout_err),
    .challenge   (challenge),
    .puf_enable  (puf_enable),
    .puf_reset   (puf_reset),
    .puf_out     (puf_out),
    .puf_done    (puf_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PUF model: out = challenge[0], latched one cycle before done, 10 cycles after enable
  logic model_mute = 1'b0;
  int   m_cnt      = 0;
  initial begin
    puf_out  = 1'b0;
    puf_done = 1'b0;
  end
  always @(posedge clk) begin
    if (puf_reset) begin
      puf_done <= 1'b0;
      m_cnt    <= 0;
    end else if (puf_enable && !puf_done && !model_mute) begin
      if (m_cnt == 8) puf_out <= challenge[0];
      if (m_cnt == 9) puf_done <= 1'b1;
      m_cnt <= m_cnt + 1;
    end
  end

  logic [7:0]    exp_chal_q[$];
  logic [NB-1:0] exp_resp_q[$];
  int            en_rises  = 0;
  int            resp_seen = 0;

  initial begin : monitor
    logic          prev_en;
    logic [7:0]    prev_chal;
    logic [7:0]    ec;
    logic [NB-1:0] er;
    prev_en   = 1'b0;
    prev_chal = 8'h00;
    forever begin
      @(negedge clk);
      if (puf_enable && !prev_en) begin
        en_rises++;
        compared++;
        if (exp_chal_q.size() == 0) begin
          mismatched++;
          $display("FAIL chal_unexpected got=%02h exp=none", challenge);
        end else begin
          ec = exp_chal_q.pop_front();
          if (challenge !== ec) begin
            mismatched++;
            $display("FAIL chal_seq got=%02h exp=%02h", challenge, ec);
          end
        end
      end
      if (resp_valid) begin
        resp_seen++;
        compared++;
        if (exp_resp_q.size() == 0) begin
          mismatched++;
          $display("FAIL resp_unexpected got=%b exp=none", response);
        end else begin
          er = exp_resp_q.pop_front();
          if (response !== er) begin
            mismatched++;
            $display("FAIL resp_word got=%b exp=%b", response, er);
          end
        end
      end
      if (puf_enable) begin
        compared++;
        assert (puf_reset === 1'b0) else begin
          mismatched++;
          $display("FAIL hs_enable_in_reset got puf_reset=%b exp=0", puf_reset);
        end
        if (prev_en) begin
          compared++;
          assert (challenge === prev_chal) else begin
            mismatched++;
            $display("FAIL hs_chal_stable got=%02h exp=%02h", challenge, prev_chal);
          end
        end
      end
      prev_en   = puf_enable;
      prev_chal = challenge;
    end
  end

  task automatic push_run(input logic [7:0] s);
    logic [7:0]    c;
    logic [NB-1:0] r;
    c = (s == 8'h00) ? 8'h01 : s;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      exp_chal_q.push_back(c);
      r[NB-1-i] = c[0];
      c = {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
    end
    exp_resp_q.push_back(r);
  endtask

  task automatic launch(input logic [7:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    push_run(s);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (resp_seen >= target) return;
    end
    compared++;
    mismatched++;
    $display("FAIL wait_resp_timeout got=%0d exp=%0d", resp_seen, target);
  endtask

  task automatic wait_rises(input int target);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (en_rises >= target) return;
    end
    compared++;
    mismatched++;
    $display("FAIL wait_enable_timeout got=%0d exp=%0d", en_rises, target);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    seed  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    compared += 7;
    if (busy !== 1'b0)        begin mismatched++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (resp_valid !== 1'b0)  begin mismatched++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL rst_timeout_err got=%b exp=0", timeout_err); end
    if (response !== '0)      begin mismatched++; $display("FAIL rst_response got=%b exp=0", response); end
    if (challenge !== 8'h00)  begin mismatched++; $display("FAIL rst_challenge got=%02h exp=00", challenge); end
    if (puf_enable !== 1'b0)  begin mismatched++; $display("FAIL rst_puf_enable got=%b exp=0", puf_enable); end
    if (puf_reset !== 1'b1)   begin mismatched++; $display("FAIL rst_puf_reset got=%b exp=1", puf_reset); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int base;
    base = resp_seen;
    @(negedge clk);
    seed  = 8'h01;
    start = 1'b1;
    push_run(8'h01);
    @(negedge clk);
    start = 1'b0;
    #1;
    compared += 2;
    if (busy !== 1'b1)       begin mismatched++; $display("FAIL basic_busy_rise got=%b exp=1", busy); end
    if (puf_enable !== 1'b0) begin mismatched++; $display("FAIL basic_enable_early got=%b exp=0", puf_enable); end
    repeat (3) @(negedge clk);
    #1;
    compared++;
    if (puf_enable !== 1'b0) begin mismatched++; $display("FAIL basic_enable_clear_end got=%b exp=0", puf_enable); end
    @(negedge clk);
    #1;
    compared++;
    if (puf_enable !== 1'b1) begin mismatched++; $display("FAIL basic_enable_rise got=%b exp=1", puf_enable); end
    wait_resp(base + 1);
    compared += 2;
    if (busy !== 1'b1)          begin mismatched++; $display("FAIL basic_busy_done got=%b exp=1", busy); end
    if (response !== 4'b1000)   begin mismatched++; $display("FAIL basic_response got=%b exp=1000", response); end
    @(negedge clk);
    #1;
    compared += 3;
    if (busy !== 1'b0)          begin mismatched++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    if (resp_valid !== 1'b0)    begin mismatched++; $display("FAIL basic_valid_pulse got=%b exp=0", resp_valid); end
    if (response !== 4'b1000)   begin mismatched++; $display("FAIL basic_response_hold got=%b exp=1000", response); end
    repeat (5) @(negedge clk);
    #1;
    compared++;
    if (resp_seen !== base + 1) begin mismatched++; $display("FAIL basic_pulse_count got=%0d exp=%0d", resp_seen, base + 1); end
  endtask

  task automatic test_zero_seed();
    int base;
    base = resp_seen;
    launch(8'h00);
    #1;
    compared++;
    if (challenge !== 8'h01) begin mismatched++; $display("FAIL zero_seed_first got=%02h exp=01", challenge); end
    wait_resp(base + 1);
  endtask

  task automatic test_timeout();
    int base;
    base = resp_seen;
    model_mute = 1'b1;
    @(negedge clk);
    seed  = 8'h37;
    start = 1'b1;
    exp_chal_q.push_back(8'h37);
    @(negedge clk);
    start = 1'b0;
    wait_rises(en_rises + 1);
    repeat (19) @(negedge clk);
    #1;
    compared += 2;
    if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL tmo_early got=%b exp=0", timeout_err); end
    if (puf_enable !== 1'b1)  begin mismatched++; $display("FAIL tmo_arm_held got=%b exp=1", puf_enable); end
    @(negedge clk);
    #1;
    compared += 3;
    if (timeout_err !== 1'b1) begin mismatched++; $display("FAIL tmo_flag got=%b exp=1", timeout_err); end
    if (puf_enable !== 1'b0)  begin mismatched++; $display("FAIL tmo_enable_drop got=%b exp=0", puf_enable); end
    if (busy !== 1'b0)        begin mismatched++; $display("FAIL tmo_idle got=%b exp=0", busy); end
    repeat (30) @(negedge clk);
    #1;
    compared += 2;
    if (timeout_err !== 1'b1) begin mismatched++; $display("FAIL tmo_sticky got=%b exp=1", timeout_err); end
    if (resp_seen !== base)   begin mismatched++; $display("FAIL tmo_no_valid got=%0d exp=%0d", resp_seen, base); end
    model_mute = 1'b0;
    launch(8'h37);
    #1;
    compared++;
    if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL tmo_clear_on_start got=%b exp=0", timeout_err); end
    wait_resp(base + 1);
  endtask

  task automatic test_reset_mid();
    int base;
    int rb;
    base = resp_seen;
    rb   = en_rises;
    launch(8'h21);
    wait_rises(rb + 3);
    reset = 1'b0;
    exp_chal_q.delete();
    exp_resp_q.delete();
    @(negedge clk);
    #1;
    compared += 5;
    if (puf_reset !== 1'b1)  begin mismatched++; $display("FAIL mid_puf_reset got=%b exp=1", puf_reset); end
    if (puf_enable !== 1'b0) begin mismatched++; $display("FAIL mid_puf_enable got=%b exp=0", puf_enable); end
    if (busy !== 1'b0)       begin mismatched++; $display("FAIL mid_busy got=%b exp=0", busy); end
    if (response !== '0)     begin mismatched++; $display("FAIL mid_response got=%b exp=0", response); end
    if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL mid_resp_valid got=%b exp=0", resp_valid); end
    reset = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    compared++;
    if (resp_seen !== base) begin mismatched++; $display("FAIL mid_no_valid got=%0d exp=%0d", resp_seen, base); end
    launch(8'h21);
    wait_resp(base + 1);
  endtask

  task automatic test_start_busy();
    int base;
    int rb;
    base = resp_seen;
    rb   = en_rises;
    launch(8'h5A);
    wait_rises(rb + 2);
    seed  = 8'hC3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_resp(base + 1);
    repeat (20) @(negedge clk);
    #1;
    compared++;
    if (exp_chal_q.size() != 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_start_ignored got=pending:%0d busy:%b exp=pending:0 busy:0", exp_chal_q.size(), busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seeds [4];
    int base;
    seeds[0] = 8'h9C;
    seeds[1] = 8'hFF;
    seeds[2] = 8'h80;
    seeds[3] = 8'h13;
    base = resp_seen;
    for (int k = 0; k < 4; k++) begin
      launch(seeds[k]);
      wait_resp(base + k + 1);
    end
    @(negedge clk);
    #1;
    compared++;
    if (exp_resp_q.size() != 0) begin mismatched++; $display("FAIL b2b_drain got=%0d exp=0", exp_resp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_seed();
    test_timeout();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=still_running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
